// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between three
// write-back requesters (ALU, load data, immediate/move). Each port has a
// one-entry holding buffer; a round-robin arbiter picks one buffered write
// per cycle, and the winner is registered onto the decoder/register-file inputs.
module wb_port_arbiter #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned ZERO_REG_LOCK = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req_valid,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_data,
    output logic [2:0]            req_ready,
    input  logic                  hold,
    output logic [ADDR_W-1:0]     c_addr,
    output logic                  load,
    output logic [DATA_W-1:0]     wdata,
    output logic [1:0]            grant_id,
    output logic                  busy
);

    localparam int unsigned NPORTS   = 3;
    localparam logic [1:0]  GID_NONE = 2'd3;

    typedef enum logic [1:0] {L0 = 2'd0, L1 = 2'd1, L2 = 2'd2} last_t;
    typedef enum logic       {EMPTY = 1'b0, FULL = 1'b1}       buf_t;

    last_t               r_last, w_last_nxt;
    buf_t                r_buf      [NPORTS];
    buf_t                w_buf_nxt  [NPORTS];
    logic [ADDR_W-1:0]   r_addr     [NPORTS];
    logic [ADDR_W-1:0]   w_addr_nxt [NPORTS];
    logic [DATA_W-1:0]   r_data     [NPORTS];
    logic [DATA_W-1:0]   w_data_nxt [NPORTS];

    logic                r_load,   w_load_nxt;
    logic [ADDR_W-1:0]   r_caddr,  w_caddr_nxt;
    logic [DATA_W-1:0]   r_wdata,  w_wdata_nxt;
    logic [1:0]          r_gid,    w_gid_nxt;

    logic                w_any;
    logic [1:0]          w_gidx;
    logic [1:0]          w_cand;
    logic [2:0]          w_grant;
    logic [2:0]          w_full;
    logic [2:0]          w_accept;

    // Next port index in rotation order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Flatten buffer state into a flag vector for ready/busy.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_full[i] = (r_buf[i] == FULL);
        end
    end

    // Round-robin pick: first FULL port after last_grant; nothing while held.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = 2'd0;
        w_cand = inc3(r_last);
        for (int k = 0; k < 3; k++) begin
            if (!w_any && !hold && w_full[w_cand]) begin
                w_any  = 1'b1;
                w_gidx = w_cand;
            end
            w_cand = inc3(w_cand);
        end
    end

    // One-hot grant vector from the winning index.
    always_comb begin
        w_grant = 3'b000;
        if (w_any) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    // Ready depends only on buffer state and grant, never on req_valid.
    assign req_ready = ~w_full | w_grant;
    assign w_accept  = req_valid & req_ready;

    // Next-state for buffers, round-robin pointer and output registers.
    always_comb begin
        w_last_nxt  = r_last;
        w_buf_nxt   = r_buf;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_load_nxt  = 1'b0;
        w_gid_nxt   = GID_NONE;
        w_caddr_nxt = r_caddr;
        w_wdata_nxt = r_wdata;

        if (w_any) begin
            w_buf_nxt[w_gidx] = EMPTY;
            w_last_nxt        = last_t'(w_gidx);
            w_load_nxt        = !((ZERO_REG_LOCK != 0) && (r_addr[w_gidx] == '0));
            w_caddr_nxt       = r_addr[w_gidx];
            w_wdata_nxt       = r_data[w_gidx];
            w_gid_nxt         = w_gidx;
        end

        // A same-cycle accept refills the slot the grant just drained.
        for (int i = 0; i < 3; i++) begin
            if (w_accept[i]) begin
                w_buf_nxt[i]  = FULL;
                w_addr_nxt[i] = req_addr[i*ADDR_W +: ADDR_W];
                w_data_nxt[i] = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last  <= L2;
            r_load  <= 1'b0;
            r_caddr <= '0;
            r_wdata <= '0;
            r_gid   <= GID_NONE;
            for (int i = 0; i < 3; i++) begin
                r_buf[i]  <= EMPTY;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_last  <= w_last_nxt;
            r_load  <= w_load_nxt;
            r_caddr <= w_caddr_nxt;
            r_wdata <= w_wdata_nxt;
            r_gid   <= w_gid_nxt;
            for (int i = 0; i < 3; i++) begin
                r_buf[i]  <= w_buf_nxt[i];
                r_addr[i] <= w_addr_nxt[i];
                r_data[i] <= w_data_nxt[i];
            end
        end
    end

    assign load     = r_load;
    assign c_addr   = r_caddr;
    assign wdata    = r_wdata;
    assign grant_id = r_gid;
    assign busy     = |w_full;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed table, multi-cycle sequences and
// random traffic against a queue-level reference model. A second instance
// with the zero-register lock enabled runs on the same stimulus.
module tb_wb_port_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       req_valid;
    logic [3*AW-1:0]  req_addr;
    logic [3*DW-1:0]  req_data;
    logic             hold;
    logic [2:0]       req_ready,  req_ready_z;
    logic [AW-1:0]    c_addr,     c_addr_z;
    logic             load,       load_z;
    logic [DW-1:0]    wdata,      wdata_z;
    logic [1:0]       grant_id,   grant_id_z;
    logic             busy,       busy_z;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG_LOCK(0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .hold(hold), .c_addr(c_addr),
        .load(load), .wdata(wdata), .grant_id(grant_id), .busy(busy));

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG_LOCK(1)) dut_z (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready_z), .hold(hold), .c_addr(c_addr_z),
        .load(load_z), .wdata(wdata_z), .grant_id(grant_id_z), .busy(busy_z));

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] seen_ready;

    // Reference model: one slot per port plus the last granted port number.
    bit            m_full [3];
    logic [AW-1:0] m_addr [3];
    logic [DW-1:0] m_data [3];
    int            m_last;
    logic          m_load, m_loadz;
    logic [AW-1:0] m_caddr;
    logic [DW-1:0] m_wdata;
    logic [1:0]    m_gid;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_pick(input logic h);
        if (h) return -1;
        for (int k = 1; k <= 3; k++) begin
            int p;
            p = (m_last + k) % 3;
            if (m_full[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [2:0] m_ready(input logic h);
        logic [2:0] r;
        int g;
        g = m_pick(h);
        for (int i = 0; i < 3; i++) r[i] = !m_full[i] || (g == i);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_full[i] = 1'b0;
            m_addr[i] = '0;
            m_data[i] = '0;
        end
        m_last  = 2;
        m_load  = 1'b0;
        m_loadz = 1'b0;
        m_caddr = '0;
        m_wdata = '0;
        m_gid   = 2'd3;
    endtask

    task automatic model_step(input logic r, input logic h, input logic [2:0] v,
                              input logic [3*AW-1:0] a, input logic [3*DW-1:0] d);
        int g;
        logic [2:0] rdy;
        if (r) begin
            model_reset();
            return;
        end
        g   = m_pick(h);
        rdy = m_ready(h);
        if (g >= 0) begin
            m_load    = 1'b1;
            m_loadz   = (m_addr[g] != '0);
            m_caddr   = m_addr[g];
            m_wdata   = m_data[g];
            m_gid     = 2'(g);
            m_full[g] = 1'b0;
            m_last    = g;
        end else begin
            m_load  = 1'b0;
            m_loadz = 1'b0;
            m_gid   = 2'd3;
        end
        for (int i = 0; i < 3; i++) begin
            if (v[i] && rdy[i]) begin
                m_full[i] = 1'b1;
                m_addr[i] = a[i*AW +: AW];
                m_data[i] = d[i*DW +: DW];
            end
        end
    endtask

    function automatic logic m_busy();
        return m_full[0] || m_full[1] || m_full[2];
    endfunction

    // One clock: drive, check ready before the edge, check outputs after it.
    task automatic tick(input logic r, input logic h, input logic [2:0] v,
                        input logic [3*AW-1:0] a, input logic [3*DW-1:0] d);
        reset = r; hold = h; req_valid = v; req_addr = a; req_data = d;
        #2;
        seen_ready = req_ready;
        check("ready",   32'(req_ready),   32'(m_ready(h)));
        check("ready_z", 32'(req_ready_z), 32'(m_ready(h)));
        @(posedge clk);
        model_step(r, h, v, a, d);
        #1;
        check("load",       32'(load),       32'(m_load));
        check("load_z",     32'(load_z),     32'(m_loadz));
        check("c_addr",     32'(c_addr),     32'(m_caddr));
        check("c_addr_z",   32'(c_addr_z),   32'(m_caddr));
        check("wdata",      32'(wdata),      32'(m_wdata));
        check("wdata_z",    32'(wdata_z),    32'(m_wdata));
        check("grant_id",   32'(grant_id),   32'(m_gid));
        check("grant_id_z", 32'(grant_id_z), 32'(m_gid));
        check("busy",       32'(busy),       32'(m_busy()));
        check("busy_z",     32'(busy_z),     32'(m_busy()));
    endtask

    typedef struct {
        logic          r;
        logic          h;
        logic [2:0]    v;
        logic [11:0]   a;
        logic [47:0]   d;
        logic [2:0]    rdy;
        logic          ld;
        logic          ldz;
        logic [3:0]    ca;
        logic [15:0]   wd;
        logic [1:0]    gid;
        logic          bz;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic h, input logic [2:0] v,
                                 input logic [11:0] a, input logic [47:0] d,
                                 input logic [2:0] rdy, input logic ld, input logic ldz,
                                 input logic [3:0] ca, input logic [15:0] wd,
                                 input logic [1:0] gid, input logic bz);
        vec_t t;
        t.r = r; t.h = h; t.v = v; t.a = a; t.d = d; t.rdy = rdy;
        t.ld = ld; t.ldz = ldz; t.ca = ca; t.wd = wd; t.gid = gid; t.bz = bz;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];

        reset = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check("rst_load",     32'(load),      32'(0));
        check("rst_grant_id", 32'(grant_id),  32'(3));
        check("rst_c_addr",   32'(c_addr),    32'(0));
        check("rst_wdata",    32'(wdata),     32'(0));
        check("rst_busy",     32'(busy),      32'(0));
        check("rst_ready",    32'(req_ready), 32'(3'b111));

        //            r  h  v       addr {p2,p1,p0}         data {p2,p1,p0}                          rdy     ld ldz ca     wd        gid bz
        tbl.push_back(mkv(0, 0, 3'b001, {4'd0, 4'd0, 4'd5}, {16'h0, 16'h0, 16'hA5A5},            3'b111, 0, 0, 4'd0, 16'h0000, 3, 1));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b111, 1, 1, 4'd5, 16'hA5A5, 0, 0));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b111, 0, 0, 4'd5, 16'hA5A5, 3, 0));
        tbl.push_back(mkv(1, 0, 3'b000, 12'h0,              48'h0,                               3'b111, 0, 0, 4'd0, 16'h0000, 3, 0));
        tbl.push_back(mkv(0, 0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111},      3'b111, 0, 0, 4'd0, 16'h0000, 3, 1));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b001, 1, 1, 4'd1, 16'h1111, 0, 1));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b011, 1, 1, 4'd2, 16'h2222, 1, 1));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b111, 1, 1, 4'd3, 16'h3333, 2, 0));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b111, 0, 0, 4'd3, 16'h3333, 3, 0));
        tbl.push_back(mkv(0, 0, 3'b101, {4'd9, 4'd0, 4'd7}, {16'h0909, 16'h0, 16'h0707},         3'b111, 0, 0, 4'd3, 16'h3333, 3, 1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mkv(0, 1, 3'b101, {4'd14, 4'd0, 4'd15}, {16'hDEAD, 16'h0, 16'hDEAD},   3'b010, 0, 0, 4'd3, 16'h3333, 3, 1));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b011, 1, 1, 4'd7, 16'h0707, 0, 1));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b111, 1, 1, 4'd9, 16'h0909, 2, 0));
        tbl.push_back(mkv(0, 0, 3'b100, {4'd12, 4'd0, 4'd0}, {16'hCCCC, 16'h0, 16'h0},           3'b111, 0, 0, 4'd9, 16'h0909, 3, 1));
        tbl.push_back(mkv(1, 0, 3'b000, 12'h0,              48'h0,                               3'b111, 0, 0, 4'd0, 16'h0000, 3, 0));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b111, 0, 0, 4'd0, 16'h0000, 3, 0));
        tbl.push_back(mkv(0, 0, 3'b010, {4'd0, 4'd0, 4'd0}, {16'h0, 16'hBEEF, 16'h0},            3'b111, 0, 0, 4'd0, 16'h0000, 3, 1));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b111, 1, 0, 4'd0, 16'hBEEF, 1, 0));
        tbl.push_back(mkv(0, 0, 3'b000, 12'h0,              48'h0,                               3'b111, 0, 0, 4'd0, 16'hBEEF, 3, 0));

        foreach (tbl[n]) begin
            tick(tbl[n].r, tbl[n].h, tbl[n].v, tbl[n].a, tbl[n].d);
            check($sformatf("tbl%0d_ready", n), 32'(seen_ready), 32'(tbl[n].rdy));
            check($sformatf("tbl%0d_load", n),  32'(load),       32'(tbl[n].ld));
            check($sformatf("tbl%0d_loadz", n), 32'(load_z),     32'(tbl[n].ldz));
            check($sformatf("tbl%0d_caddr", n), 32'(c_addr),     32'(tbl[n].ca));
            check($sformatf("tbl%0d_wdata", n), 32'(wdata),      32'(tbl[n].wd));
            check($sformatf("tbl%0d_gid", n),   32'(grant_id),   32'(tbl[n].gid));
            check($sformatf("tbl%0d_busy", n),  32'(busy),       32'(tbl[n].bz));
        end

        // Port 1 streams eight writes back to back.
        for (int k = 0; k < 10; k++) begin
            logic [2:0] v;
            v = (k < 8) ? 3'b010 : 3'b000;
            tick(1'b0, 1'b0, v, {4'd0, 4'(k), 4'd0}, {16'h0, 16'(16'h0100 + k), 16'h0});
            if (k < 8) check("stream_ready", 32'(seen_ready[1]), 32'(1));
            if (k >= 1 && k <= 8) begin
                check("stream_load",  32'(load),   32'(1));
                check("stream_addr",  32'(c_addr), 32'(k - 1));
                check("stream_wdata", 32'(wdata),  32'(16'h0100 + k - 1));
            end
        end

        // All three ports continuously valid: grants rotate 0,1,2.
        tick(1'b1, 1'b0, 3'b000, 12'h0, 48'h0);
        tick(1'b0, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3000, 16'h2000, 16'h1000});
        for (int c = 1; c <= 12; c++) begin
            tick(1'b0, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1},
                 {16'(16'h3000 + c), 16'(16'h2000 + c), 16'(16'h1000 + c)});
            check("rot_gid",  32'(grant_id), 32'((c - 1) % 3));
            check("rot_load", 32'(load),     32'(1));
        end
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 3'b000, 12'h0, 48'h0);
        check("rot_drained_busy", 32'(busy), 32'(0));

        // Random traffic with occasional hold and reset.
        for (int c = 0; c < 600; c++) begin
            logic r, h;
            r = ($urandom_range(0, 59) == 0);
            h = ($urandom_range(0, 4) == 0);
            tick(r, h, 3'($urandom), 12'($urandom),
                 {16'($urandom), 16'($urandom), 16'($urandom)});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
